ant_noc_scheduler: RTL and testbench
====================================

Name: ant_noc_scheduler

Overview:
- Central scheduler for the PageRank array.
- Round-robin arbitrates remote page-value requests from NUM_ANT ant blocks. Routes each winning request as a query to the owning ant, captures that ant's reply, and returns it to the requester as a {data,page_id} response.
- Also counts PageRank iterations from per-ant sweep completions and halts service once ITER_MAX iterations finish.

Parameters:
- NUM_ANT, 4, number of ant blocks (power of 2).
- N, 16, pages owned per ant; page owner = page / N.
- WIDTH, 16, fixed-point value width.
- REPLY_LAT, 1, cycles from query drive to valid reply (1..3).
- ITER_MAX, 32, iterations before done.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears counters and enables service.
- req_valid  in  NUM_ANT  per-ant remote request pending.
- req_page  in  NUM_ANT*6  per-ant requested global page id; ant a at [a*6+:6].
- req_ready  out  NUM_ANT  one-hot grant/accept.
- query_valid  out  1  query bus valid.
- query  out  6  global page id driven to owner.
- query_dst  out  log2(NUM_ANT)  owning ant index.
- reply_in  in  NUM_ANT*WIDTH  per-ant reply bus; ant a at [a*WIDTH+:WIDTH].
- resp_valid  out  NUM_ANT  one-hot response strobe.
- response  out  WIDTH+6  {data,page_id}.
- sweep_done  in  NUM_ANT  per-ant pulse when its page counter wraps N-1 to 0.
- iter_count  out  8  completed iterations.
- busy  out  1  high while running and not done.
- done  out  1  sticky; iter_count reached ITER_MAX.
- err_self  out  1  sticky; an ant requested a page it owns.

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, all outputs 0, sweep_seen=0, running=0.
- start=1 in any state:
  - clears iter_count, done, err_self, sweep_seen; sets running=1.
  - aborts any in-flight transaction to IDLE with no response; the requester keeps req_valid and is re-arbitrated.
- FSM IDLE:
  - If running & !done & |req_valid, grant the first asserted req_valid starting at rr_ptr, wrapping.
  - req_ready[g]=1 combinationally in IDLE only; accept = req_valid[g]&req_ready[g].
  - On accept (cycle T): latch page=req_page[g], owner=page[5:log2(N)], requester g; rr_ptr<=(g+1) mod NUM_ANT; go QUERY.
- FSM QUERY:
  - Cycles T+1..T+REPLY_LAT: query_valid=1, query=page, query_dst=owner.
  - Wait counter runs 0..REPLY_LAT-1.
  - At the end of cycle T+REPLY_LAT, sample reply_in[owner]; go RESP.
- FSM RESP:
  - Cycle T+REPLY_LAT+1: resp_valid[g]=1, response={reply,page}; return to IDLE.
  - Accept-to-response latency = REPLY_LAT+1. Minimum spacing between accepts = REPLY_LAT+2 cycles.
- query, query_dst and response hold their last values when not valid. Strobes are one cycle.
- If owner==requester, set err_self and still serve normally.
- Requester must hold req_valid until its resp_valid; a deassert after accept is ignored.
- Iterations:
  - sweep_seen |= sweep_done each cycle while running.
  - When sweep_seen is all-ones (including the same-cycle OR): iter_count+1 and sweep_seen cleared; a sweep_done arriving in that same cycle is kept in the new sweep_seen.
  - When the increment reaches ITER_MAX: done=1, busy=0, running=0. No new grants after that; an in-flight transaction completes.
  - Multiple sweep_done from one ant before the others count once.
  - iter_count saturates at 255.
- busy = running & !done.

Test Plan:
- Reset (reset=0), then reset=1, start: all outputs 0 until start; busy=1 after start.
- Single request, REPLY_LAT=1: ant1 req_page=6'd37 at T:
  - T+1: query=37, query_dst=2.
  - reply_in[2]=16'h1234.
  - T+2: resp_valid=4'b0010, response={16'h1234,6'd37}.
- Fairness: all four req_valid held high → grant order 0,1,2,3,0, one accept every 3 cycles.
- Self request: ant0 req_page=5 → err_self=1, response still delivered to ant0.
- Iterations, ITER_MAX=2:
  - sweep_done pulses ant0 twice, then ants1-3 → iter_count=1.
  - Repeat → iter_count=2, done=1, req_ready stays 0 under requests.
- start mid-QUERY: no resp_valid for the aborted request; iter_count=0; the request is re-granted and completes.

Source files
------------

// File: rtl/ant_noc_scheduler_if.sv
// Ant-array <-> scheduler bundle: remote page requests, owner query bus, per-ant replies and responses.
// The ant side drives requests and replies (master); the scheduler drives grants, queries and responses (slave).
interface ant_noc_scheduler_if #(
    parameter int NUM_ANT = 4,
    parameter int WIDTH   = 16
);
    localparam int DST_W = (NUM_ANT > 1) ? $clog2(NUM_ANT) : 1;

    logic [NUM_ANT-1:0]       req_valid;
    logic [NUM_ANT*6-1:0]     req_page;
    logic [NUM_ANT-1:0]       req_ready;
    logic                     query_valid;
    logic [5:0]               query;
    logic [DST_W-1:0]         query_dst;
    logic [NUM_ANT*WIDTH-1:0] reply_in;
    logic [NUM_ANT-1:0]       resp_valid;
    logic [WIDTH+5:0]         response;

    modport master (
        output req_valid, req_page, reply_in,
        input  req_ready, query_valid, query, query_dst, resp_valid, response
    );

    modport slave (
        input  req_valid, req_page, reply_in,
        output req_ready, query_valid, query, query_dst, resp_valid, response
    );
endinterface

// File: rtl/ant_noc_scheduler.sv
// Round-robin page-request scheduler and iteration counter for the PageRank ant array.
// Accept-to-response REPLY_LAT+1 cycles; one transaction in flight, req_ready only offered in IDLE.
module ant_noc_scheduler #(
    parameter int NUM_ANT   = 4,
    parameter int N         = 16,
    parameter int WIDTH     = 16,
    parameter int REPLY_LAT = 1,
    parameter int ITER_MAX  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    ant_noc_scheduler_if.slave bus,
    input  logic [NUM_ANT-1:0] sweep_done,
    output logic [7:0]         iter_count,
    output logic               busy,
    output logic               done,
    output logic               err_self
);
    localparam int DST_W = (NUM_ANT > 1) ? $clog2(NUM_ANT) : 1;
    localparam int NLOG  = $clog2(N);
    localparam logic [31:0] ITER_LIM = 32'(ITER_MAX);

    typedef enum logic [1:0] {IDLE, QUERY, RESP} state_t;

    state_t             state, state_nxt;
    logic [DST_W-1:0]   rr_ptr, req_g, owner_q, grant_idx, scan_idx, owner_in;
    logic               grant_any, can_grant, accept, running;
    logic [NUM_ANT-1:0] grant_oh, resp_oh, sweep_seen, seen_or;
    logic [5:0]         page_q, page_in;
    logic [1:0]         wait_cnt;
    logic [WIDTH-1:0]   reply_sel;
    logic [WIDTH+5:0]   resp_q;
    logic [7:0]         iter_inc;

    // First pending requester at or after rr_ptr; index arithmetic wraps because NUM_ANT is a power of 2.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_ANT; i++) begin
            scan_idx = rr_ptr + DST_W'(i);
            if (!grant_any && bus.req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign page_in   = bus.req_page[grant_idx*6 +: 6];
    assign owner_in  = DST_W'(page_in >> NLOG);
    assign reply_sel = bus.reply_in[owner_q*WIDTH +: WIDTH];
    assign can_grant = running & ~done & ~start & grant_any;

    always_comb begin
        state_nxt = state;
        grant_oh  = '0;
        resp_oh   = '0;
        case (state)
            IDLE: begin
                if (can_grant) begin
                    grant_oh[grant_idx] = 1'b1;
                    state_nxt           = QUERY;
                end
            end
            QUERY: begin
                if (wait_cnt == 2'(REPLY_LAT - 1)) state_nxt = RESP;
            end
            RESP: begin
                resp_oh[req_g] = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // start abandons whatever is in flight; the requester is simply re-arbitrated later.
        if (start) state_nxt = IDLE;
    end

    assign accept          = |grant_oh;
    assign bus.req_ready   = grant_oh;
    assign bus.resp_valid  = resp_oh;
    assign bus.query_valid = (state == QUERY);
    assign bus.query       = page_q;
    assign bus.query_dst   = owner_q;
    assign bus.response    = resp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            req_g    <= '0;
            owner_q  <= '0;
            page_q   <= '0;
            wait_cnt <= '0;
            resp_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                page_q   <= page_in;
                owner_q  <= owner_in;
                req_g    <= grant_idx;
                rr_ptr   <= grant_idx + DST_W'(1);
                wait_cnt <= '0;
            end else if (state == QUERY) begin
                wait_cnt <= wait_cnt + 2'd1;
                if (state_nxt == RESP) resp_q <= {reply_sel, page_q};
            end
        end
    end

    assign seen_or  = sweep_seen | sweep_done;
    assign iter_inc = (iter_count == 8'hFF) ? iter_count : iter_count + 8'd1;
    assign busy     = running & ~done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running    <= 1'b0;
            done       <= 1'b0;
            err_self   <= 1'b0;
            iter_count <= '0;
            sweep_seen <= '0;
        end else if (start) begin
            running    <= 1'b1;
            done       <= 1'b0;
            err_self   <= 1'b0;
            iter_count <= '0;
            sweep_seen <= '0;
        end else begin
            if (accept && owner_in == grant_idx) err_self <= 1'b1;
            if (running) begin
                if (&seen_or) begin
                    // Pulses landing on the completing cycle already belong to the next sweep.
                    sweep_seen <= sweep_done;
                    iter_count <= iter_inc;
                    if ({24'd0, iter_inc} == ITER_LIM) begin
                        done    <= 1'b1;
                        running <= 1'b0;
                    end
                end else begin
                    sweep_seen <= seen_or;
                end
            end
        end
    end
endmodule

// File: tb/tb_ant_noc_scheduler.sv
// Directed bench for ant_noc_scheduler with a response scoreboard fed from observed grants.
module tb_ant_noc_scheduler;
    localparam int NUM_ANT   = 4;
    localparam int WIDTH     = 16;
    localparam int N         = 16;
    localparam int REPLY_LAT = 1;
    localparam int ITER_MAX  = 2;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [3:0] sweep_done;
    logic [7:0] iter_count;
    logic       busy, done, err_self;

    always #5 clk = ~clk;

    ant_noc_scheduler_if #(.NUM_ANT(NUM_ANT), .WIDTH(WIDTH)) bus ();

    ant_noc_scheduler #(
        .NUM_ANT(NUM_ANT), .N(N), .WIDTH(WIDTH), .REPLY_LAT(REPLY_LAT), .ITER_MAX(ITER_MAX)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus.slave),
        .sweep_done(sweep_done), .iter_count(iter_count), .busy(busy),
        .done(done), .err_self(err_self)
    );

    typedef struct {
        logic [3:0]  who;
        logic [21:0] resp;
        int          c;
    } exp_t;

    exp_t        exp_q[$];
    int          g_idx[$];
    int          g_cyc[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    logic [15:0] rep[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_replies();
        for (int a = 0; a < NUM_ANT; a++) bus.reply_in[a*WIDTH +: WIDTH] = rep[a];
    endtask

    task automatic set_page(input int a, input logic [5:0] p);
        bus.req_page[a*6 +: 6] = p;
    endtask

    // Samples outputs on the falling edge, then advances to just after the next rising edge.
    task automatic tick();
        exp_t       e;
        int         g;
        int         owner;
        logic [5:0] pg;
        @(negedge clk);
        if (bus.resp_valid !== 4'b0) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(bus.resp_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("resp_who", 32'(bus.resp_valid), 32'(e.who));
                check("resp_dat", 32'(bus.response), 32'(e.resp));
                check("resp_lat", 32'(cyc - e.c), 32'(REPLY_LAT + 1));
            end
        end
        if (bus.req_ready !== 4'b0) begin
            g = 0;
            for (int a = 0; a < NUM_ANT; a++) if (bus.req_ready[a]) g = a;
            check("grant_onehot", 32'($countones(bus.req_ready)), 1);
            pg     = bus.req_page[g*6 +: 6];
            owner  = int'(pg) / N;
            e.who  = 4'b0001 << g;
            e.resp = {rep[owner], pg};
            e.c    = cyc;
            exp_q.push_back(e);
            g_idx.push_back(g);
            g_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check({tag, "_drained"}, 32'(exp_q.size()), 0);
    endtask

    task automatic pulse(input logic [3:0] m);
        sweep_done = m;
        tick();
        sweep_done = 4'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        sweep_done    = 4'b0;
        bus.req_valid = 4'b0;
        bus.req_page  = '0;
        rep[0] = 16'hA0A0; rep[1] = 16'hB1B1; rep[2] = 16'hC2C2; rep[3] = 16'hD3D3;
        set_replies();
        #12;
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_qv", 32'(bus.query_valid), 0);
        check("rst_resp", 32'({bus.resp_valid, bus.response}), 0);
        check("rst_query", 32'({bus.query_dst, bus.query}), 0);
        check("rst_status", 32'({iter_count, busy, done, err_self}), 0);

        // Requests before start must not be served.
        @(negedge clk);
        reset = 1'b1;
        set_page(0, 6'd20); set_page(1, 6'd40); set_page(2, 6'd60); set_page(3, 6'd10);
        bus.req_valid = 4'hF;
        tick(); tick();
        check("prestart_grants", 32'(g_idx.size()), 0);
        check("prestart_busy", 32'(busy), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);

        // Fairness with all four requesting.
        for (int i = 0; i < 60 && g_idx.size() < 5; i++) tick();
        bus.req_valid = 4'b0;
        check("fair_count", 32'(g_idx.size()), 5);
        if (g_idx.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("fair_order", 32'(g_idx[i]), 32'(i % 4));
                if (i > 0) check("fair_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'(REPLY_LAT + 2));
            end
        end
        drain("fair");
        check("fair_err_self", 32'(err_self), 0);

        // Single request: ant1 asks for page 37, owned by ant2.
        g_idx.delete();
        set_page(1, 6'd37);
        rep[2] = 16'h1234;
        set_replies();
        bus.req_valid = 4'b0010;
        tick();
        check("single_grant", 32'(g_idx.size()), 1);
        check("single_qv", 32'(bus.query_valid), 1);
        check("single_query", 32'(bus.query), 37);
        check("single_dst", 32'(bus.query_dst), 2);
        tick();
        check("single_rv", 32'(bus.resp_valid), 32'(4'b0010));
        check("single_resp", 32'(bus.response), 32'({16'h1234, 6'd37}));
        tick();
        bus.req_valid = 4'b0;
        tick();
        check("single_hold_qv", 32'(bus.query_valid), 0);
        check("single_hold_query", 32'({bus.query_dst, bus.query}), 32'({2'd2, 6'd37}));
        check("single_hold_resp", 32'(bus.response), 32'({16'h1234, 6'd37}));
        check("single_drained", 32'(exp_q.size()), 0);

        // Self request: ant0 asks for page 5, which it owns.
        check("self_pre", 32'(err_self), 0);
        set_page(0, 6'd5);
        bus.req_valid = 4'b0001;
        tick();
        check("self_err", 32'(err_self), 1);
        drain("self");
        bus.req_valid = 4'b0;

        // Iterations: duplicate pulses from one ant count once.
        pulse(4'b0001); pulse(4'b0001); pulse(4'b0010); pulse(4'b0100);
        check("iter_partial", 32'(iter_count), 0);
        pulse(4'b1000);
        check("iter_one", 32'(iter_count), 1);
        check("iter_one_done", 32'({busy, done}), 32'(2'b10));
        pulse(4'b0001); pulse(4'b0001); pulse(4'b0010); pulse(4'b0100); pulse(4'b1000);
        check("iter_two", 32'(iter_count), 2);
        check("iter_two_done", 32'({busy, done}), 32'(2'b01));
        g_idx.delete();
        bus.req_valid = 4'hF;
        repeat (6) tick();
        check("done_no_grant", 32'(g_idx.size()), 0);
        check("done_ready", 32'(bus.req_ready), 0);
        bus.req_valid = 4'b0;

        // start during QUERY aborts without a response; the request is re-granted.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_status", 32'({iter_count, busy, done, err_self}), 32'({8'd0, 3'b100}));
        g_idx.delete();
        set_page(2, 6'd50);
        bus.req_valid = 4'b0100;
        tick();
        check("abort_in_query", 32'(bus.query_valid), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        check("abort_idle", 32'({bus.query_valid, bus.resp_valid}), 0);
        check("abort_iter", 32'(iter_count), 0);
        tick();
        drain("abort");
        bus.req_valid = 4'b0;
        check("abort_regrants", 32'(g_idx.size()), 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
